// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
//  mem_size_e   : access size encoding (B=00, H=01, W=10; 11 is treated as W)
//  lsu_state_e  : LSU controller states
//  lsu_norm_size: folds the reserved 11 encoding onto W
//  lsu_extract  : pulls a byte/half/word out of a memory word and extends it
//  lsu_merge    : places store bytes into a memory word (little endian)
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        MemB = 2'b00,
        MemH = 2'b01,
        MemW = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        StIdle,
        StLdReq,
        StLdWait,
        StRmwReq,
        StRmwWait,
        StStReq,
        StStWait,
        StResp
    } lsu_state_e;

    function automatic mem_size_e lsu_norm_size(input logic [1:0] raw);
        return (raw == 2'b11) ? MemW : mem_size_e'(raw);
    endfunction

    function automatic logic [31:0] lsu_extract(input mem_size_e   size,
                                                input logic [1:0]  offset,
                                                input logic        is_unsigned,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = '0;
        res     = word;
        case (size)
            MemB: begin
                shifted = word >> {offset, 3'b000};
                res     = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            MemH: begin
                shifted = word >> {offset[1], 4'b0000};
                res     = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lsu_merge(input mem_size_e   size,
                                              input logic [1:0]  offset,
                                              input logic [31:0] st_data,
                                              input logic [31:0] word);
        logic [31:0] res;
        res = word;
        case (size)
            MemB:    res[{offset, 3'b000} +: 8]     = st_data[7:0];
            MemH:    res[{offset[1], 4'b0000} +: 16] = st_data[15:0];
            default: res = st_data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
//  master modport: execute-stage side (drives requests, accepts responses)
//  slave modport : LSU side (accepts requests, drives responses)
//  req_*  : valid/ready request with store flag, size, unsigned flag, address, data, tag
//  resp_* : valid/ready response with load data, echoed tag and misaligned flag
interface load_store_unit_if #(
    parameter int unsigned TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_is_store;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_misaligned;

    modport master (
        output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_data, req_tag,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_data, resp_tag, resp_misaligned
    );

    modport slave (
        input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_data, req_tag,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_data, resp_tag, resp_misaligned
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational data alignment for the load/store unit.
//  size_i, offset_i, unsigned_i : access descriptor (offset = byte address [1:0])
//  rd_word_i                    : word returned by data memory
//  st_data_i                    : right-justified store data
//  ld_data_o                    : extracted and sign/zero extended load result
//  merged_o                     : rd_word_i with the store bytes patched in
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  mem_size_e   size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] st_data_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] merged_o
);
    always_comb begin
        ld_data_o = lsu_extract(size_i, offset_i, unsigned_i, rd_word_i);
        merged_o  = lsu_merge(size_i, offset_i, st_data_i, rd_word_i);
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one byte/half/word request at a time into whole-word
// data-memory read/write pulses. Sub-word stores use read-modify-write; loads
// are extracted and extended. One response per accepted request.
//  clk_i, reset_i   : clock, synchronous active-high reset
//  bus              : request/response channel (slave side)
//  dmem_read_o      : one-cycle read pulse
//  dmem_write_o     : one-cycle write pulse
//  dmem_addr_o      : word index
//  dmem_data_o      : full word to write
//  dmem_rd_data_i   : read word, valid with dmem_done_i
//  dmem_done_i      : one-cycle completion pulse
// Optional: LSU_MISALIGN_TRAP_EN makes misaligned H/W accesses skip memory and
// respond with resp_misaligned=1; otherwise low address bits are forced aligned.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned WORD_ADDR_W = 18
) (
    input  logic              clk_i,
    input  logic              reset_i,
    load_store_unit_if.slave  bus,
    output logic              dmem_read_o,
    output logic              dmem_write_o,
    output logic [31:0]       dmem_addr_o,
    output logic [31:0]       dmem_data_o,
    input  logic [31:0]       dmem_rd_data_i,
    input  logic              dmem_done_i
);
    localparam int unsigned AddrW = WORD_ADDR_W + 2;

    lsu_state_e       state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    mem_size_e        size_q, size_d;
    logic             unsigned_q, unsigned_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      word_q, word_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [31:0]      ld_data;
    logic [31:0]      merged;
    mem_size_e        req_size;
    logic [AddrW-1:0] req_addr_al;
    logic             req_mis;
    logic             unused_addr;

    assign unused_addr = ^bus.req_addr[31:AddrW];
    assign req_size    = lsu_norm_size(bus.req_size);

    // Force alignment; with the trap enabled misaligned requests never touch
    // memory, so the masked address is harmless there too.
    always_comb begin
        req_addr_al = bus.req_addr[AddrW-1:0];
        if (req_size == MemH) req_addr_al[0]   = 1'b0;
        if (req_size == MemW) req_addr_al[1:0] = 2'b00;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign req_mis = ((req_size == MemH) && bus.req_addr[0]) ||
                     ((req_size == MemW) && (bus.req_addr[1:0] != 2'b00));
    assign bus.resp_misaligned = mis_q;
`else
    assign req_mis             = 1'b0;
    assign bus.resp_misaligned = 1'b0;
`endif

    load_store_unit_align u_align (
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .rd_word_i  (dmem_rd_data_i),
        .st_data_i  (data_q),
        .ld_data_o  (ld_data),
        .merged_o   (merged)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        data_d        = data_q;
        word_d        = word_q;
        resp_data_d   = resp_data_q;
        tag_d         = tag_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d         = mis_q;
`endif
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        dmem_read_o    = 1'b0;
        dmem_write_o   = 1'b0;
        dmem_data_o    = '0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d      = req_addr_al;
                    size_d      = req_size;
                    unsigned_d  = bus.req_unsigned;
                    data_d      = bus.req_data;
                    word_d      = bus.req_data;
                    tag_d       = bus.req_tag;
                    resp_data_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d       = req_mis;
`endif
                    if (req_mis)                state_d = StResp;
                    else if (!bus.req_is_store) state_d = StLdReq;
                    else if (req_size == MemW)  state_d = StStReq;
                    else                        state_d = StRmwReq;
                end
            end
            StLdReq: begin
                dmem_read_o = 1'b1;
                state_d     = StLdWait;
            end
            StLdWait: begin
                if (dmem_done_i) begin
                    resp_data_d = ld_data;
                    state_d     = StResp;
                end
            end
            StRmwReq: begin
                dmem_read_o = 1'b1;
                state_d     = StRmwWait;
            end
            StRmwWait: begin
                if (dmem_done_i) begin
                    word_d  = merged;
                    state_d = StStReq;
                end
            end
            StStReq: begin
                dmem_write_o = 1'b1;
                dmem_data_o  = word_q;
                state_d      = StStWait;
            end
            StStWait: begin
                if (dmem_done_i) state_d = StResp;
            end
            StResp: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            size_q      <= MemB;
            unsigned_q  <= 1'b0;
            data_q      <= '0;
            word_q      <= '0;
            resp_data_q <= '0;
            tag_q       <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            data_q      <= data_d;
            word_q      <= word_d;
            resp_data_q <= resp_data_d;
            tag_q       <= tag_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

    assign dmem_addr_o   = {{(32 - WORD_ADDR_W){1'b0}}, addr_q[AddrW-1:2]};
    assign bus.resp_data = resp_data_q;
    assign bus.resp_tag  = tag_q;
endmodule
